// File: rtl/io_pkg.sv
// Shared constants and types for the processor I/O port peripheral.
// Optional build macro used by the top: IO_OVF_IRQ_EN (output-overflow interrupt).
package io_pkg;

   localparam int IN_PORT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } inState_t;

   localparam int IRQ_IN_READY = 0;
   localparam int IRQ_OUT_OVF  = 1;

endpackage

// File: rtl/io_port_peripheral_if.sv
// Bundle of processor-side and device-side I/O port signals.
// Handshakes: a word moves on a rising edge only when its valid and ready are both 1;
// the sender holds data stable while valid is high and ready is low.
interface io_port_if
   import io_pkg::*;
#(
   parameter int DATA_W = IN_PORT_WIDTH,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] outPortData;
   logic              outSignalEn;
   logic [DATA_W-1:0] inPortData;
   logic [1:0]        interruptSignal;
   logic [DATA_W-1:0] devOutData;
   logic              devOutValid;
   logic              devOutReady;
   logic [DATA_W-1:0] devInData;
   logic              devInValid;
   logic              devInReady;
   logic [CNT_W-1:0]  outCount;
   inState_t          inState;

   modport slave (
      input  outPortData, outSignalEn, devOutReady, devInData, devInValid,
      output inPortData, interruptSignal, devOutData, devOutValid, devInReady,
             outCount, inState
   );

   modport master (
      output outPortData, outSignalEn, devOutReady, devInData, devInValid,
      input  inPortData, interruptSignal, devOutData, devOutValid, devInReady,
             outCount, inState
   );

endinterface

// File: rtl/io_fifo.sv
// First-word fall-through FIFO for processor OUT words; power-of-2 depth,
// wrapping pointers, synchronous active-low reset that also clears storage.
module io_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] pushData,
   input  logic              pop,
   output logic [DATA_W-1:0] headData,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;

   assign headData = mem[rdPtr];
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);

   // Storage is cleared on reset so the head word never reads as X.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wrPtr] <= pushData;
            wrPtr      <= wrPtr + PTR_W'(1);
         end
         if (pop) rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/io_port_peripheral.sv
// Device-side endpoint of the processor I/O port: OUT FIFO toward the device, input
// capture FSM with interrupt pulse. Define IO_OVF_IRQ_EN to enable the overflow interrupt.
module io_port_peripheral
   import io_pkg::*;
#(
   parameter int DATA_W     = IN_PORT_WIDTH,
   parameter int DEPTH      = 4,
   parameter int IRQ_CYCLES = 1,
   parameter int IRQ_GAP    = 2
) (
   input logic       clk,
   input logic       reset,
   io_port_if.slave  bus
);

   localparam int IRQ_MAX = (IRQ_CYCLES > IRQ_GAP) ? IRQ_CYCLES : IRQ_GAP;
   localparam int CW      = $clog2(IRQ_MAX + 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(IRQ_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'((IRQ_GAP > 0) ? IRQ_GAP - 1 : 0);

   logic fifoFull;
   logic fifoEmpty;
   logic push;
   logic pop;

   assign pop  = !fifoEmpty && bus.devOutReady;
   // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
   assign push = bus.outSignalEn && (!fifoFull || pop);

   io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) outFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pushData (bus.outPortData),
      .pop      (pop),
      .headData (bus.devOutData),
      .count    (bus.outCount),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   assign bus.devOutValid = !fifoEmpty;

   inState_t          state;
   logic [CW-1:0]     cnt;
   logic              irqIn;
   logic              irqOvf;
   logic [DATA_W-1:0] inWord;

   assign bus.devInReady = (state == IDLE) && reset;
   assign bus.inPortData = inWord;
   assign bus.inState    = state;
   assign bus.interruptSignal[IRQ_IN_READY] = irqIn;
   assign bus.interruptSignal[IRQ_OUT_OVF]  = irqOvf;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         irqIn  <= 1'b0;
         inWord <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.devInValid) begin
                  inWord <= bus.devInData;
                  cnt    <= PULSE_LOAD;
                  irqIn  <= 1'b1;
                  state  <= PULSE;
               end
            end
            PULSE: begin
               if (cnt == '0) begin
                  irqIn <= 1'b0;
                  if (IRQ_GAP > 0) begin
                     cnt   <= GAP_LOAD;
                     state <= GAP;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            GAP: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IO_OVF_IRQ_EN
   logic drop;
   assign drop = bus.outSignalEn && fifoFull && !pop;

   // One pulse per discarded write, in the cycle after it.
   always_ff @(posedge clk) begin
      if (!reset) irqOvf <= 1'b0;
      else        irqOvf <= drop;
   end
`else
   assign irqOvf = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_peripheral.sv
// Self-checking bench for io_port_peripheral: vector table, directed corner cases and
// randomized traffic compared against a queue/timeline reference model.
module tb_io_port_peripheral;
   import io_pkg::*;

   localparam int DATA_W     = 16;
   localparam int DEPTH      = 4;
   localparam int IRQ_CYCLES = 1;
   localparam int IRQ_GAP    = 2;
   localparam int SPACING    = IRQ_CYCLES + IRQ_GAP + 1;
`ifdef IO_OVF_IRQ_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic reset3;
   always #5 clk = ~clk;

   io_port_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
   io_port_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus3 ();

   io_port_peripheral #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IRQ_CYCLES(IRQ_CYCLES),
                        .IRQ_GAP(IRQ_GAP)) dut (
      .clk (clk), .reset (reset), .bus (bus)
   );

   io_port_peripheral #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IRQ_CYCLES(3),
                        .IRQ_GAP(0)) dut3 (
      .clk (clk), .reset (reset3), .bus (bus3)
   );

   // ---------------- scoreboard / reference model ----------------
   int tests = 0;
   int fails = 0;

   logic [DATA_W-1:0] expQ[$];
   logic [DATA_W-1:0] refIn;
   logic              refOvf;
   int                capCycle;
   int                cyc;

   function automatic bit modelReady();
      return cyc >= capCycle + SPACING;
   endfunction

   function automatic bit modelIrqIn();
      return (cyc >= capCycle + 1) && (cyc <= capCycle + IRQ_CYCLES);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      expQ.delete();
      refIn    = '0;
      refOvf   = 1'b0;
      capCycle = -1000;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic rst, input logic en, input logic [DATA_W-1:0] data,
                        input logic rdy, input logic iv, input logic [DATA_W-1:0] id);
      @(negedge clk);
      reset           = rst;
      bus.outSignalEn = en;
      bus.outPortData = data;
      bus.devOutReady = rdy;
      bus.devInValid  = iv;
      bus.devInData   = id;
      #1;
   endtask

   task automatic modelCheck();
      check("outCount", 32'(bus.outCount), 32'(expQ.size()));
      check("devOutValid", 32'(bus.devOutValid), 32'(expQ.size() != 0));
      if (expQ.size() != 0) check("devOutData", 32'(bus.devOutData), 32'(expQ[0]));
      check("inPortData", 32'(bus.inPortData), 32'(refIn));
      check("irqInReady", 32'(bus.interruptSignal[IRQ_IN_READY]), 32'(modelIrqIn()));
      check("irqOutOvf", 32'(bus.interruptSignal[IRQ_OUT_OVF]), 32'(refOvf));
      check("devInReady", 32'(bus.devInReady), 32'(reset && modelReady()));
   endtask

   // Advance the model across the coming rising edge using the inputs just driven.
   task automatic modelAdvance();
      bit p, u;
      if (!reset) begin
         modelReset();
      end else begin
         p = (expQ.size() != 0) && bus.devOutReady;
         u = bus.outSignalEn && ((expQ.size() < DEPTH) || p);
         refOvf = OVF_ON && bus.outSignalEn && !u;
         if (p) void'(expQ.pop_front());
         if (u) expQ.push_back(bus.outPortData);
         if (bus.devInValid && modelReady()) begin
            capCycle = cyc;
            refIn    = bus.devInData;
         end
      end
      cyc++;
   endtask

   task automatic step(input logic rst, input logic en, input logic [DATA_W-1:0] data,
                       input logic rdy, input logic iv, input logic [DATA_W-1:0] id);
      drive(rst, en, data, rdy, iv, id);
      modelCheck();
      modelAdvance();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic              en;
      logic [DATA_W-1:0] data;
      logic              rdy;
      int                expCount;
      logic              expValid;
      logic [DATA_W-1:0] expHead;
      logic              expOvf;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(logic en, logic [DATA_W-1:0] data, logic rdy, int cnt,
                               logic valid, logic [DATA_W-1:0] head, logic ovf);
      vec_t v;
      v.en = en; v.data = data; v.rdy = rdy; v.expCount = cnt;
      v.expValid = valid; v.expHead = head; v.expOvf = ovf;
      return v;
   endfunction

   initial begin
      // OUT burst then drain
      tbl[0]  = mk(1, 16'h0011, 0, 0, 0, 16'h0000, 0);
      tbl[1]  = mk(1, 16'h0022, 0, 1, 1, 16'h0011, 0);
      tbl[2]  = mk(1, 16'h0033, 0, 2, 1, 16'h0011, 0);
      tbl[3]  = mk(0, 16'h0000, 0, 3, 1, 16'h0011, 0);
      tbl[4]  = mk(0, 16'h0000, 1, 3, 1, 16'h0011, 0);
      tbl[5]  = mk(0, 16'h0000, 1, 2, 1, 16'h0022, 0);
      tbl[6]  = mk(0, 16'h0000, 1, 1, 1, 16'h0033, 0);
      tbl[7]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0);
      // overflow: fifth word dropped
      tbl[8]  = mk(1, 16'hA000, 0, 0, 0, 16'h0000, 0);
      tbl[9]  = mk(1, 16'hA001, 0, 1, 1, 16'hA000, 0);
      tbl[10] = mk(1, 16'hA002, 0, 2, 1, 16'hA000, 0);
      tbl[11] = mk(1, 16'hA003, 0, 3, 1, 16'hA000, 0);
      tbl[12] = mk(1, 16'hA004, 0, 4, 1, 16'hA000, 0);
      tbl[13] = mk(0, 16'h0000, 0, 4, 1, 16'hA000, OVF_ON);
      // full plus pop: 0xBEEF accepted, count held
      tbl[14] = mk(1, 16'hBEEF, 1, 4, 1, 16'hA000, 0);
      tbl[15] = mk(0, 16'h0000, 1, 4, 1, 16'hA001, 0);
      tbl[16] = mk(0, 16'h0000, 1, 3, 1, 16'hA002, 0);
      tbl[17] = mk(0, 16'h0000, 1, 2, 1, 16'hA003, 0);
      tbl[18] = mk(0, 16'h0000, 1, 1, 1, 16'hBEEF, 0);
      tbl[19] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0);
   end

   // ---------------- test sequence ----------------
   initial begin
      reset = 1'b0;
      reset3 = 1'b0;
      bus.outSignalEn = 0; bus.outPortData = '0; bus.devOutReady = 0;
      bus.devInValid = 0; bus.devInData = '0;
      bus3.outSignalEn = 0; bus3.outPortData = '0; bus3.devOutReady = 0;
      bus3.devInValid = 0; bus3.devInData = '0;
      cyc = 0;
      modelReset();

      // First edge brings registers out of X; checks start once reset has been applied.
      drive(0, 0, '0, 0, 1, 16'h7777);
      modelAdvance();
      for (int i = 0; i < 3; i++) begin
         step(0, 0, '0, 0, 1, 16'h7777);
         check("rst_devInReady", 32'(bus.devInReady), 32'd0);
         check("rst_inPortData", 32'(bus.inPortData), 32'd0);
      end
      drive(1, 0, '0, 0, 0, '0);
      check("release_devInReady", 32'(bus.devInReady), 32'd1);
      modelCheck();
      modelAdvance();

      for (int i = 0; i < 20; i++) begin
         drive(1, tbl[i].en, tbl[i].data, tbl[i].rdy, 0, '0);
         check($sformatf("tbl%0d_count", i), 32'(bus.outCount), 32'(tbl[i].expCount));
         check($sformatf("tbl%0d_valid", i), 32'(bus.devOutValid), 32'(tbl[i].expValid));
         if (tbl[i].expValid)
            check($sformatf("tbl%0d_head", i), 32'(bus.devOutData), 32'(tbl[i].expHead));
         check($sformatf("tbl%0d_ovf", i), 32'(bus.interruptSignal[IRQ_OUT_OVF]),
               32'(tbl[i].expOvf));
         modelCheck();
         modelAdvance();
      end

      // Input capture with devInValid held: one capture every SPACING cycles.
      for (int i = 0; i < 12; i++) begin
         drive(1, 0, '0, 0, 1, 16'h1234);
         check($sformatf("cap%0d_ready", i), 32'(bus.devInReady), 32'((i % SPACING) == 0));
         check($sformatf("cap%0d_irq", i), 32'(bus.interruptSignal[IRQ_IN_READY]),
               32'((i % SPACING) == 1));
         if (i >= 1) check($sformatf("cap%0d_data", i), 32'(bus.inPortData), 32'h1234);
         modelCheck();
         modelAdvance();
      end
      for (int i = 0; i < SPACING; i++) step(1, 0, '0, 0, 0, '0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 60) != 0), 1'($urandom_range(0, 1)), 16'($urandom),
              ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 16'($urandom));
      end
      step(1, 0, '0, 0, 0, '0);

      // Mid-pulse reset on the IRQ_CYCLES=3 instance.
      @(negedge clk);
      reset3 = 1'b1;
      bus3.devInValid = 1'b1;
      bus3.devInData  = 16'h5A5A;
      #1;
      check("mp_ready_idle", 32'(bus3.devInReady), 32'd1);
      @(negedge clk);
      bus3.devInValid = 1'b0;
      #1;
      check("mp_pulse1_irq", 32'(bus3.interruptSignal[IRQ_IN_READY]), 32'd1);
      check("mp_pulse1_data", 32'(bus3.inPortData), 32'h5A5A);
      check("mp_pulse1_ready", 32'(bus3.devInReady), 32'd0);
      @(negedge clk);
      #1;
      check("mp_pulse2_irq", 32'(bus3.interruptSignal[IRQ_IN_READY]), 32'd1);
      reset3 = 1'b0;
      @(negedge clk);
      #1;
      check("mp_rst_irq", 32'(bus3.interruptSignal[IRQ_IN_READY]), 32'd0);
      check("mp_rst_data", 32'(bus3.inPortData), 32'd0);
      check("mp_rst_state", 32'(bus3.inState), 32'(IDLE));
      reset3 = 1'b1;
      #1;
      check("mp_release_ready", 32'(bus3.devInReady), 32'd1);
      @(negedge clk);
      #1;
      check("mp_after_irq", 32'(bus3.interruptSignal[IRQ_IN_READY]), 32'd0);
      check("mp_after_state", 32'(bus3.inState), 32'(IDLE));

      // ---------------- final report ----------------
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
